// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one single-port memory,
// with byte-lane steering, right-justified load return and a req/ack timeout.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned AW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [1:0]    d_size,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_ack,
    output logic [31:0]   d_rdata,
    output logic          err,
    output logic          stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [1:0]    state_q, state_d;
    logic          last_data_q, last_data_d;  // 1: data path held the most recent grant
    logic [1:0]    lane_q, lane_d;
    logic [1:0]    size_q, size_d;
    logic          we_q, we_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          if_ack_q, if_ack_d, d_ack_q, d_ack_d, err_q, err_d;
    logic [31:0]   if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;

    logic        if_elig, d_elig, d_mis;
    logic [3:0]  d_be;
    logic [31:0] d_lanes, rd_shift, load_data;

    assign if_elig = if_req & ~if_ack_q;
    assign d_elig  = d_req & ~d_ack_q;
    assign d_mis   = (d_size == 2'b11) || (d_size == 2'b01 && d_addr[0]) ||
                     (d_size == 2'b10 && d_addr[1:0] != 2'b00);

    always_comb begin
        case (d_size)
            2'b00:   begin d_be = 4'b0001 << d_addr[1:0]; d_lanes = {4{d_wdata[7:0]}};  end
            2'b01:   begin d_be = 4'b0011 << d_addr[1:0]; d_lanes = {2{d_wdata[15:0]}}; end
            default: begin d_be = 4'b1111;                d_lanes = d_wdata;            end
        endcase
    end

    assign rd_shift = mem_rdata >> {lane_q, 3'b000};

    always_comb begin
        case (size_q)
            2'b00:   load_data = {24'b0, rd_shift[7:0]};
            2'b01:   load_data = {16'b0, rd_shift[15:0]};
            default: load_data = rd_shift;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        last_data_d = last_data_q;
        lane_d      = lane_q;
        size_d      = size_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        err_d       = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (d_elig && (!if_elig || !last_data_q)) begin
                    last_data_d = 1'b1;
                    lane_d      = d_addr[1:0];
                    size_d      = d_size;
                    we_d        = d_we;
                    if (d_mis) begin
                        d_ack_d   = 1'b1;
                        err_d     = 1'b1;
                        d_rdata_d = '0;
                    end else begin
                        state_d     = DATA;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = d_we;
                        mem_addr_d  = {d_addr[AW-1:2], 2'b00};
                        mem_be_d    = d_be;
                        mem_wdata_d = d_lanes;
                    end
                end else if (if_elig) begin
                    last_data_d = 1'b0;
                    if (if_addr[1:0] != 2'b00) begin
                        if_ack_d   = 1'b1;
                        err_d      = 1'b1;
                        if_rdata_d = '0;
                    end else begin
                        state_d    = FETCH;
                        cnt_d      = '0;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {if_addr[AW-1:2], 2'b00};
                        mem_be_d   = 4'b1111;
                    end
                end
            end
            FETCH, DATA: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (state_q == FETCH) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = we_q ? 32'b0 : load_data;
                    end
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    err_d     = 1'b1;
                    if (state_q == FETCH) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = '0;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = '0;
                    end
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            last_data_q <= 1'b0;
            lane_q      <= '0;
            size_q      <= '0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_data_q <= last_data_d;
            lane_q      <= lane_d;
            size_q      <= size_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            err_q       <= err_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign err       = err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign stall     = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a byte-level reference model.
module tb_mem_port_arbiter;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_ack, d_req, d_we, d_ack, err, stall;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic [1:0]  d_size;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int tests = 0;
    int fails = 0;
    bit last_data;  // model: data path held the most recent grant

    mem_port_arbiter #(.TIMEOUT(TO), .AW(32)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .err(err), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte-level view: an access of n bytes at offset off touches lanes off..off+n-1.
    task automatic model(input bit we, input logic [1:0] size, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, output bit mis,
                         output logic [3:0] be, output logic [31:0] ewd,
                         output logic [31:0] erd);
        int n, off;
        n   = 1 << size;
        off = int'(a[1:0]);
        mis = (size == 2'b11) || ((off % n) != 0);
        be  = '0;
        ewd = '0;
        erd = '0;
        if (!mis) begin
            for (int k = 0; k < n; k++) be[off + k] = 1'b1;
            for (int k = 0; k < 4; k++) ewd[8*k +: 8] = wd[8*(k % n) +: 8];
            if (!we) for (int i = 0; i < n; i++) erd[8*i +: 8] = rd[8*(off + i) +: 8];
        end
    endtask

    // Called at the first busy negedge; returns at the negedge after completion/abort.
    task automatic busy_wait(input int lat, input logic [31:0] rd, output bit timed_out);
        timed_out = (lat >= int'(TO));
        repeat (timed_out ? int'(TO) - 1 : lat) @(negedge clk);
        check("mem_req_held", {31'b0, mem_req}, 32'd1);
        if (!timed_out) begin
            mem_ack   = 1'b1;
            mem_rdata = rd;
        end
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
    endtask

    task automatic fetch_txn(input logic [31:0] a, input logic [31:0] rd, input int lat);
        bit to;
        if_req  = 1'b1;
        if_addr = a;
        #1;
        check("if_stall_pending", {31'b0, stall}, 32'd1);
        @(negedge clk);
        last_data = 1'b0;
        if (a[1:0] != 2'b00) begin
            check("if_mis_ack", {31'b0, if_ack}, 32'd1);
            check("if_mis_err", {31'b0, err}, 32'd1);
            check("if_mis_rdata", if_rdata, 32'd0);
            check("if_mis_no_mem", {31'b0, mem_req}, 32'd0);
        end else begin
            check("if_mem_req", {31'b0, mem_req}, 32'd1);
            check("if_mem_addr", mem_addr, {a[31:2], 2'b00});
            check("if_mem_be", {28'b0, mem_be}, 32'hf);
            check("if_mem_we", {31'b0, mem_we}, 32'd0);
            busy_wait(lat, rd, to);
            check("if_ack", {31'b0, if_ack}, 32'd1);
            check("if_err", {31'b0, err}, {31'b0, to});
            check("if_rdata", if_rdata, to ? 32'd0 : rd);
            check("if_mem_req_drop", {31'b0, mem_req}, 32'd0);
            check("if_stall_ack", {31'b0, stall}, 32'd0);
        end
        if_req = 1'b0;
        @(negedge clk);
        check("if_ack_pulse", {31'b0, if_ack}, 32'd0);
    endtask

    task automatic data_txn(input bit we, input logic [1:0] size, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd, input int lat);
        bit mis, to;
        logic [3:0] ebe;
        logic [31:0] ewd, erd;
        model(we, size, a, wd, rd, mis, ebe, ewd, erd);
        d_req   = 1'b1;
        d_we    = we;
        d_size  = size;
        d_addr  = a;
        d_wdata = wd;
        #1;
        check("d_stall_pending", {31'b0, stall}, 32'd1);
        @(negedge clk);
        last_data = 1'b1;
        if (mis) begin
            check("d_mis_ack", {31'b0, d_ack}, 32'd1);
            check("d_mis_err", {31'b0, err}, 32'd1);
            check("d_mis_rdata", d_rdata, 32'd0);
            check("d_mis_no_mem", {31'b0, mem_req}, 32'd0);
        end else begin
            check("d_mem_req", {31'b0, mem_req}, 32'd1);
            check("d_mem_addr", mem_addr, {a[31:2], 2'b00});
            check("d_mem_be", {28'b0, mem_be}, {28'b0, ebe});
            check("d_mem_we", {31'b0, mem_we}, {31'b0, we});
            if (we) check("d_mem_wdata", mem_wdata, ewd);
            busy_wait(lat, rd, to);
            check("d_ack", {31'b0, d_ack}, 32'd1);
            check("d_err", {31'b0, err}, {31'b0, to});
            check("d_rdata", d_rdata, to ? 32'd0 : erd);
            check("d_mem_req_drop", {31'b0, mem_req}, 32'd0);
            check("d_stall_ack", {31'b0, stall}, 32'd0);
        end
        d_req = 1'b0;
        @(negedge clk);
        check("d_ack_pulse", {31'b0, d_ack}, 32'd0);
    endtask

    // Both request together; the winner is dropped in its ack cycle, the loser follows.
    task automatic tie_txn(input bit exp_data_first);
        bit to;
        if_req = 1'b1; if_addr = 32'h400;
        d_req  = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h500;
        @(negedge clk);
        check("tie_first", mem_addr, exp_data_first ? 32'h500 : 32'h400);
        busy_wait(0, 32'h1111_2222, to);
        check("tie_first_ack", {30'b0, d_ack, if_ack},
              exp_data_first ? 32'd2 : 32'd1);
        if (exp_data_first) d_req = 1'b0; else if_req = 1'b0;
        @(negedge clk);
        check("tie_second", mem_addr, exp_data_first ? 32'h400 : 32'h500);
        busy_wait(0, 32'h3333_4444, to);
        check("tie_second_ack", {30'b0, d_ack, if_ack},
              exp_data_first ? 32'd1 : 32'd2);
        if_req = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);
        last_data = !exp_data_first;
    endtask

    initial begin
        reset = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_size = '0; d_addr = '0; d_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        last_data = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_be", {28'b0, mem_be}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_acks", {29'b0, if_ack, d_ack, err}, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // First tie after reset goes to data.
        tie_txn(1'b1);
        data_txn(1'b0, 2'b10, 32'h0000_0600, 32'h0, 32'hCAFE_F00D, 1);
        tie_txn(1'b0);

        fetch_txn(32'h0000_0100, 32'h1234_5678, 2);
        data_txn(1'b1, 2'b00, 32'h0000_0203, 32'h0000_00AB, 32'h0, 0);
        data_txn(1'b0, 2'b01, 32'h0000_0302, 32'h0, 32'hBEEF_1234, 1);
        data_txn(1'b0, 2'b01, 32'h0000_0301, 32'h0, 32'h0, 0);
        data_txn(1'b0, 2'b11, 32'h0000_0300, 32'h0, 32'h0, 0);
        fetch_txn(32'h0000_0102, 32'h0, 0);

        // Timeout, ack on the timeout cycle, then normal traffic.
        data_txn(1'b0, 2'b10, 32'h0000_0700, 32'h0, 32'h5555_AAAA, 10);
        fetch_txn(32'h0000_0704, 32'h0BAD_CAFE, int'(TO) - 1);
        fetch_txn(32'h0000_0708, 32'hDEAD_BEEF, 1);

        // mem_ack while idle is ignored.
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("idle_ack_ignored", {29'b0, if_ack, d_ack, err}, 32'd0);
        check("idle_ack_no_req", {31'b0, mem_req}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, wd, rd;
            int lat;
            a   = {20'b0, 12'($urandom)};
            wd  = $urandom;
            rd  = $urandom;
            lat = int'($urandom_range(0, 5));
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                fetch_txn(a, rd, lat);
            end else begin
                data_txn(1'($urandom), 2'($urandom), a, wd, rd, lat);
            end
        end
        tie_txn(!last_data);

        // Asynchronous reset in the middle of a data transaction.
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h0000_0800;
        @(negedge clk);
        check("pre_rst_mem_req", {31'b0, mem_req}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("async_rst_acks", {29'b0, if_ack, d_ack, err}, 32'd0);
        check("async_rst_be", {28'b0, mem_be}, 32'd0);
        d_req = 1'b0;
        @(negedge clk);
        check("rst_held_no_ack", {30'b0, if_ack, d_ack}, 32'd0);
        reset = 1'b1;
        last_data = 1'b0;
        @(negedge clk);
        tie_txn(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the core's instruction-fetch path and the load/store path. The single-cycle datapath assumes separate memories; this block lets both run against one unified RAM.
- Arbitrates the two requesters and handles the memory req/ack handshake with a timeout.
- Builds byte enables and lane-shifted store data from the access size. Returns load data right-justified in bits [7:0]/[15:0], so the datapath load-extension logic works unchanged.
- Provides a stall signal used to freeze the PC register.

Parameters:
TIMEOUT, 16, memory wait cycles before a transaction is aborted with err; 0 disables the timeout.
AW, 32, address width.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request, held until if_ack
if_addr  in  AW  fetch address (word access)
if_ack  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  32  fetched instruction
d_req  in  1  data request, held until d_ack
d_we  in  1  1=store, 0=load
d_size  in  2  00 byte, 01 half, 10 word, 11 illegal
d_addr  in  AW  byte address (ALU result)
d_wdata  in  32  store data, right-justified
d_ack  out  1  one-cycle pulse: d_rdata valid / store done
d_rdata  out  32  load data, right-justified, upper bits zero
err  out  1  one-cycle pulse with the ack of a faulted access
stall  out  1  high while any request is pending and not yet acked
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  AW  word-aligned address ({addr[AW-1:2],2'b00})
mem_be  out  4  byte-lane enables
mem_wdata  out  32  lane-shifted store data
mem_rdata  in  32  memory read data, valid with mem_ack
mem_ack  in  1  memory completion

Behaviour:
- FSM states: IDLE, FETCH, DATA. All outputs except stall are registered.
- Reset values: state=IDLE, last_grant=FETCH, all acks/err/mem_req/mem_we=0, mem_be=0, data/address outputs=0, timeout counter=0.
- Reset asserting mid-transaction clears everything immediately, including mem_req. The memory transaction is abandoned and no ack is produced.
- IDLE eligibility: a requester is eligible if its req=1 and its ack is not currently high, so the cycle in which the requester is still dropping req does not re-grant it.
- IDLE grant, one eligible: grant it.
- IDLE grant, both eligible: grant the one opposite last_grant. After reset, data wins the first tie.
- On grant: latch addr, size, we and wdata; update last_grant.
- Grant to fetch: go to FETCH. mem_req=1 and mem_we=0 on the next cycle.
- Grant to data: go to DATA.
- Alignment check at grant: misaligned accesses cause no memory access. The arbiter pulses ack+err on the next cycle (rdata=0) and stays in IDLE.
  - Misaligned fetch: if_addr[1:0]!=0.
  - Misaligned data: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
- Byte enables by size:
  - byte: mem_be=0001<<addr[1:0], mem_wdata = d_wdata[7:0] replicated in all four lanes.
  - half: mem_be=0011<<addr[1:0], mem_wdata = d_wdata[15:0] replicated in both halves.
  - word: mem_be=1111.
  - Fetch and load requests also drive mem_be per size (fetch=1111).
- Busy (FETCH/DATA): mem_req stays 1 and addr/be/wdata stay stable until mem_ack is sampled 1. On that edge:
  - mem_req goes low and the requester's ack pulses high for one cycle.
  - rdata is registered: fetch takes mem_rdata unchanged; a data load takes mem_rdata>>(8*addr[1:0]), masked to 8/16/32 bits; a store returns rdata=0.
  - State returns to IDLE, so back-to-back grants are possible at most every 2 cycles of overhead.
- Timeout: the counter increments each busy cycle without mem_ack. When the count reaches TIMEOUT (TIMEOUT>0), the arbiter aborts with ack+err (rdata=0) and returns to IDLE. mem_ack arriving in the same cycle as the timeout wins: normal completion, no err.
- mem_ack while IDLE is ignored.
- stall = (if_req & ~if_ack) | (d_req & ~d_ack), combinational.

Test Plan:
1. Fetch only, if_addr=0x100, mem_ack 2 cycles after mem_req -> mem_addr=0x100, mem_be=1111; if_ack pulses once with if_rdata=mem_rdata; stall low in the ack cycle.
2. if_req and d_req asserted together right after reset -> data granted first, then fetch; next simultaneous pair -> fetch first (alternation).
3. Store byte d_addr=0x203, d_wdata=0x000000AB -> mem_addr=0x200, mem_be=1000, mem_wdata=0xABABABAB, mem_we=1.
4. Load half d_addr=0x302, mem_rdata=0xBEEF1234 -> d_rdata=0x0000BEEF. Load half at 0x301 -> err+d_ack, mem_req never asserted.
5. TIMEOUT=4, mem_ack held low -> mem_req deasserts after 4 busy cycles, err+ack pulse, rdata=0; the next request proceeds normally.
6. reset pulled low while in DATA with mem_req=1 -> mem_req, acks and stall-causing state clear asynchronously; after release the first tie grants data.
